// File: rtl/cu_fsm_if.sv
// -----------------------------------------------------------------------------
// cu_fsm_if : control bundle between the multicycle control unit and the
//             RV32I datapath.
//
// Signals
//   intr      datapath -> cu : level interrupt request (already MIE-masked)
//   opcode    datapath -> cu : ir[6:0] of the current instruction
//   func3     datapath -> cu : ir[14:12] of the current instruction
//   PC_WE     cu -> datapath : PC register write enable
//   RF_WE     cu -> datapath : register file write enable
//   memWE2    cu -> datapath : data-port write enable
//   memRDEN1  cu -> datapath : instruction-port read enable
//   memRDEN2  cu -> datapath : data-port read enable
//   reset     cu -> datapath : synchronous clear of the PC register
//   csr_WE    cu -> datapath : CSR file write enable
//   int_taken cu -> datapath : interrupt entry (PC <- mtvec, save mepc, clear MIE)
//
// Modports
//   master : the control unit, which drives every enable
//   slave  : the datapath side, which drives the decode fields and intr
// -----------------------------------------------------------------------------
interface cu_fsm_if;
  logic       intr;
  logic [6:0] opcode;
  logic [2:0] func3;

  logic       PC_WE;
  logic       RF_WE;
  logic       memWE2;
  logic       memRDEN1;
  logic       memRDEN2;
  logic       reset;
  logic       csr_WE;
  logic       int_taken;

  modport master (
    input  intr, opcode, func3,
    output PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken
  );

  modport slave (
    output intr, opcode, func3,
    input  PC_WE, RF_WE, memWE2, memRDEN1, memRDEN2, reset, csr_WE, int_taken
  );
endinterface

// File: rtl/cu_fsm.sv
// -----------------------------------------------------------------------------
// cu_fsm : multicycle control unit for the RV32I MCU core.
//
// Each instruction walks FETCH -> EXEC [-> WB for loads] [-> INTR] -> FETCH.
// The datapath is purely combinational; this block only chooses the cycle on
// which its results are committed, by raising exactly one set of write
// enables for one cycle per instruction.
//
// Ports
//   CLK  in  : system clock, rising edge active
//   RST  in  : asynchronous active-high reset, forces ST_INIT
//   bus       : cu_fsm_if.master (decode inputs, intr, all enables)
// -----------------------------------------------------------------------------
module cu_fsm (
  input  logic     CLK,
  input  logic     RST,
  cu_fsm_if.master bus
);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WB    = 3'd3,
    ST_INTR  = 3'd4
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_CSRRW  = 3'b001;

  state_t r_state;
  logic   w_is_load;

  assign w_is_load = (bus.opcode == OP_LOAD);

  // ---------------------------------------------------------------------------
  // State register. intr is looked at only on the edge that ends an
  // instruction (EXEC of a non-load, or WB), so the current instruction
  // always finishes before interrupt entry.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its inputs from before the edge, independent of block ordering.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= ST_INIT;
    end else begin
      case (r_state)
        ST_INIT:  r_state <= ST_FETCH;
        ST_FETCH: r_state <= ST_EXEC;
        ST_EXEC: begin
          if (w_is_load)     r_state <= ST_WB;
          else if (bus.intr) r_state <= ST_INTR;
          else               r_state <= ST_FETCH;
        end
        ST_WB:    r_state <= bus.intr ? ST_INTR : ST_FETCH;
        ST_INTR:  r_state <= ST_FETCH;
        // Unused 3-bit encodings recover through INIT, which also clears PC.
        default:  r_state <= ST_INIT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode. Outputs are combinational from the state register so that
  // an asynchronous RST drops every write enable within the same cycle, and
  // so EXEC can follow the opcode fetched in the previous cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every output gets a default before the case; any path that left
  // one unassigned would infer a latch.
  always_comb begin
    bus.PC_WE     = 1'b0;
    bus.RF_WE     = 1'b0;
    bus.memWE2    = 1'b0;
    bus.memRDEN1  = 1'b0;
    bus.memRDEN2  = 1'b0;
    bus.reset     = 1'b0;
    bus.csr_WE    = 1'b0;
    bus.int_taken = 1'b0;

    case (r_state)
      ST_INIT: begin
        bus.reset = 1'b1;
      end

      ST_FETCH: begin
        bus.memRDEN1 = 1'b1;
      end

      ST_EXEC: begin
        case (bus.opcode)
          // PC advances in WB, once the load data is back.
          OP_LOAD: begin
            bus.memRDEN2 = 1'b1;
          end
          OP_STORE: begin
            bus.memWE2 = 1'b1;
            bus.PC_WE  = 1'b1;
          end
          // Taken/not-taken is resolved by the PC mux select, not here.
          OP_BRANCH: begin
            bus.PC_WE = 1'b1;
          end
          OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
            bus.PC_WE = 1'b1;
            bus.RF_WE = 1'b1;
          end
          // CSRRW writes rd and the CSR; MRET and other func3 only move PC.
          OP_SYSTEM: begin
            bus.PC_WE = 1'b1;
            if (bus.func3 == F3_CSRRW) begin
              bus.RF_WE  = 1'b1;
              bus.csr_WE = 1'b1;
            end
          end
          // Undefined opcodes retire as NOPs; no illegal-instruction trap.
          default: begin
            bus.PC_WE = 1'b1;
          end
        endcase
      end

      ST_WB: begin
        bus.RF_WE = 1'b1;
        bus.PC_WE = 1'b1;
      end

      ST_INTR: begin
        bus.int_taken = 1'b1;
        bus.PC_WE     = 1'b1;
      end

      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Structural invariants of the decode above.
  // ---------------------------------------------------------------------------
  a_data_port_excl: assert property (@(posedge CLK) disable iff (RST)
    !(bus.memWE2 && bus.memRDEN2));

  a_intr_excl: assert property (@(posedge CLK) disable iff (RST)
    !(bus.int_taken && (bus.RF_WE || bus.csr_WE || bus.memWE2)));

endmodule
